// File: rtl/fc_pkg.sv
// Shared constants and types for the fully_connected layer and its input packer.
package fc_pkg;

    localparam int FC_FAN_IN_W = 960;
    localparam int FC_NODES    = 10;
    localparam int FC_BIAS_W   = 8;
    localparam int FC_OUT_W    = 17;

    typedef enum logic {FILL, HOLD} fc_pack_state_t;

    typedef logic [FC_FAN_IN_W-1:0] fc_vec_t;

endpackage

// File: rtl/fc_beat_popcount.sv
// Combinational count of set bits in one activation beat.
module fc_beat_popcount #(
    parameter  int BEAT_W = 32,
    localparam int CNT_W  = $clog2(BEAT_W + 1)
) (
    input  logic [BEAT_W-1:0] bits_i,
    output logic [CNT_W-1:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < BEAT_W; i++) begin
            count_o = count_o + CNT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/fc_fan_in_packer.sv
// Packs BEAT_W-bit activation beats MSB-first into one FAN_IN_W-bit fan_in vector.
// Define FC_PACK_POPCNT_EN to accumulate the vector popcount; otherwise popcount reads 0.
//
// state | meaning
// FILL  | accepting beats into fan_in, in_ready high (except during rst)
// HOLD  | complete vector presented, out_valid high, input stalled
module fc_fan_in_packer
    import fc_pkg::*;
#(
    parameter int FAN_IN_W = FC_FAN_IN_W,
    parameter int BEAT_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BEAT_W-1:0]             in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FAN_IN_W-1:0]           fan_in,
    output logic [$clog2(FAN_IN_W+1)-1:0] popcount,
    output logic                          frame_err
);

    localparam int BEATS = FAN_IN_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PC_W  = $clog2(FAN_IN_W + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if (FAN_IN_W % BEAT_W != 0) begin : g_bad_width
            $error("fc_fan_in_packer: FAN_IN_W must be a multiple of BEAT_W");
        end
    endgenerate

    fc_pack_state_t       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FAN_IN_W-1:0]  fan_in_q, fan_in_d;
    logic                 frame_err_q, frame_err_d;
    logic                 accept;
    logic                 last_beat;

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fan_in_d    = fan_in_q;
        frame_err_d = 1'b0;
        in_ready    = (state_q == FILL) && !rst;
        out_valid   = (state_q == HOLD);
        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            fan_in_d[FAN_IN_W-1-b*BEAT_W -: BEAT_W] = in_data;
                        end
                    end
                    if (last_beat) begin
                        state_d     = HOLD;
                        frame_err_d = !in_last;
                    end else if (in_last) begin
                        // Short frame: restart at beat 0, stale bits get overwritten.
                        cnt_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            fan_in_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fan_in_q    <= fan_in_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign fan_in    = fan_in_q;
    assign frame_err = frame_err_q;

`ifdef FC_PACK_POPCNT_EN
    logic [$clog2(BEAT_W+1)-1:0] beat_pc;
    logic [PC_W-1:0]             pop_q, pop_d;

    fc_beat_popcount #(.BEAT_W(BEAT_W)) u_beat_popcount (
        .bits_i  (in_data),
        .count_o (beat_pc)
    );

    always_comb begin
        pop_d = pop_q;
        if (accept) begin
            if (!last_beat && in_last) begin
                pop_d = '0;
            end else if (cnt_q == '0) begin
                pop_d = PC_W'(beat_pc);
            end else begin
                pop_d = pop_q + PC_W'(beat_pc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_q <= '0;
        end else begin
            pop_q <= pop_d;
        end
    end

    assign popcount = pop_q;
`else
    assign popcount = '0;
`endif

endmodule
